tl_a_burst_arbiter: RTL and testbench
=====================================

Name: tl_a_burst_arbiter

Overview:
- N-to-1 arbiter for the TileLink A channel.
- Shares one device-side A link between NumHosts host links using round-robin priority.
- Holds the grant for every beat of a multi-beat request, so bursts are never interleaved.
- Sits at the host side of crossbars and adapters, in front of any downstream beat counter.

Parameters:
- NumHosts, 2, number of requesting host A links (>=2).
- DataWidth, 64, A-channel data width in bits; NonBurstSize = log2(DataWidth/8).
- MaxSize, 6, largest legal log2 transfer size; MaxBurstLen = 2**(MaxSize-NonBurstSize).
- PayloadWidth, 128, width of the opaque remaining A fields (param, source, address, mask, corrupt, data).

Ports:
- clk_i  input  1  clock; all state on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- host_valid_i  input  NumHosts  per-host A valid.
- host_ready_o  output  NumHosts  per-host A ready.
- host_opcode_i  input  NumHosts x 3  per-host A opcode.
- host_size_i  input  NumHosts x 4  per-host A size (log2 bytes).
- host_payload_i  input  NumHosts x PayloadWidth  per-host remaining fields.
- dev_valid_o  output  1  device A valid.
- dev_ready_i  input  1  device A ready.
- dev_opcode_o  output  3  muxed opcode.
- dev_size_o  output  4  muxed size.
- dev_payload_o  output  PayloadWidth  muxed payload.
- grant_o  output  log2(NumHosts)  index of the host currently selected.
- locked_o  output  1  a grant is held (burst in progress or beat stalled).

Behaviour:
- Beat count:
  - Opcodes 0..3 (PutFull, PutPartial, Arithmetic, Logical) carry data: beats = 2**(size-NonBurstSize) when size>NonBurstSize, else 1.
  - All other opcodes: beats = 1.
- States: IDLE, LOCKED.
- IDLE:
  - The round-robin picker selects the first valid host at or after prio_q, wrapping modulo NumHosts. Selection is combinational, zero latency.
  - dev_valid_o = OR of host_valid_i. dev fields are muxed from the selected host.
  - host_ready_o[sel] = dev_ready_i; all other bits 0.
- IDLE, handshake on a 1-beat request: stay IDLE; prio_q <= sel+1 (wrapping).
- IDLE, handshake on a multi-beat request: go to LOCKED; owner_q <= sel; left_q <= beats-2.
- IDLE, dev_valid_o high but no handshake: go to LOCKED with owner_q <= sel and left_q <= beats-1.
  - Purpose: freeze the selection so device-visible valid/data stay stable per TileLink.
- LOCKED:
  - Only owner_q is muxed and can receive ready; other hosts get ready=0 even if valid.
  - On handshake with left_q==0: go to IDLE; prio_q <= owner_q+1.
  - On handshake with left_q>0: left_q decrements.
  - The beat count is taken from the first beat only; size/opcode changes on later beats are ignored.
- If the owner drops valid mid-burst (protocol violation): stay LOCKED, dev_valid_o=0, no state change.
- grant_o: sel in IDLE, owner_q in LOCKED. locked_o = (state==LOCKED).
- Reset, any time including mid-burst:
  - state=IDLE, prio_q=0, owner_q=0, left_q=0.
  - All host_ready_o=0 and dev_valid_o=0 while rst_i is high.
  - First grant after reset goes to the lowest-index valid host.
- left_q width is vbits(MaxBurstLen); it never underflows.
- No combinational path from dev_ready_i to dev_valid_o.

Decomposition:
- tl_pkg holds:
  - the A opcode enum;
  - the TL size width constant;
  - a shared function burst_beats(opcode, size, NonBurstSize) used by all burst-aware blocks.
- Sub-module tl_rr_picker, parameterised by N:
  - inputs: request vector, priority pointer;
  - outputs: one-hot grant, encoded index, any-valid.
  - Reused by the C- and E-channel arbiters.

Test Plan:
- Single Get: host1 valid, opcode 4, size 3, dev_ready=1 -> one-cycle handshake; grant_o=1; locked_o stays 0; next priority starts at host0 (2 hosts, wrap).
- Burst lock: host0 PutFull size 6 (8 beats) with host1 valid throughout -> host_ready_o[1]=0 for all 8 beats; host1 granted on the cycle after the 8th handshake.
- Fairness: both hosts issue continuous single-beat Gets -> grants alternate 0,1,0,1 over 8 handshakes.
- Stall stability: host0 valid, dev_ready=0 for 5 cycles, then host1 raises valid -> grant_o stays 0, dev fields unchanged, host0 accepted when ready rises.
- Bubble: owner drops valid after beat 3 of 8 for 4 cycles -> dev_valid_o=0, locked_o=1, host1 blocked; burst completes after 5 more handshakes.
- Reset mid-burst: assert rst_i after beat 2 of 8 -> outputs return to reset values immediately; after release, a new single Get from host1 completes normally.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink definitions: A-channel opcodes, size field width and
// the burst beat-count helper used by every burst-aware block.
package tl_pkg;

    localparam int unsigned TlSizeW = 4;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        ArithmeticData = 3'd2,
        LogicalData    = 3'd3,
        Get            = 3'd4,
        Intent         = 3'd5,
        AcquireBlock   = 3'd6,
        AcquirePerm    = 3'd7
    } tl_a_op_e;

    // Only data-carrying opcodes span several beats; everything else is
    // a single beat regardless of size.
    function automatic int unsigned burst_beats(
        input logic [2:0]         opcode,
        input logic [TlSizeW-1:0] size,
        input int unsigned        non_burst
    );
        int unsigned beats;
        beats = 32'd1;
        if (opcode <= 3'(LogicalData) && 32'(size) > non_burst) begin
            beats = 32'd1 << (32'(size) - non_burst);
        end
        return beats;
    endfunction

endpackage

// File: rtl/tl_rr_picker.sv
// Round-robin picker: first requester at or after the priority pointer.
// Ports: req_i (N), prio_i (idx) -> gnt_o (one-hot), idx_o, any_o.
module tl_rr_picker
    import tl_pkg::*;
#(
    parameter int N    = 2,
    parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] prio_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);

    int  cand;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(prio_i) + k) % N;
            if (!found && req_i[IdxW'(cand)]) begin
                found               = 1'b1;
                idx_o               = IdxW'(cand);
                gnt_o[IdxW'(cand)] = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/tl_a_burst_arbiter.sv
// N-to-1 TileLink A-channel arbiter, round-robin, burst-atomic grants.
// Ports: host_* (N request links), dev_* (shared link), grant_o, locked_o.
module tl_a_burst_arbiter
    import tl_pkg::*;
#(
    parameter int NumHosts     = 2,
    parameter int DataWidth    = 64,
    parameter int MaxSize      = 6,
    parameter int PayloadWidth = 128
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumHosts-1:0]                    host_valid_i,
    output logic [NumHosts-1:0]                    host_ready_o,
    input  logic [NumHosts-1:0][2:0]               host_opcode_i,
    input  logic [NumHosts-1:0][TlSizeW-1:0]       host_size_i,
    input  logic [NumHosts-1:0][PayloadWidth-1:0]  host_payload_i,
    output logic                                   dev_valid_o,
    input  logic                                   dev_ready_i,
    output logic [2:0]                             dev_opcode_o,
    output logic [TlSizeW-1:0]                     dev_size_o,
    output logic [PayloadWidth-1:0]                dev_payload_o,
    output logic [$clog2(NumHosts)-1:0]            grant_o,
    output logic                                   locked_o
);

    localparam int unsigned NonBurstSize = $clog2(DataWidth / 8);
    localparam int unsigned MaxBurstLen  = 2 ** (MaxSize - NonBurstSize);
    localparam int          LeftW        = (MaxBurstLen > 1) ? $clog2(MaxBurstLen) : 1;
    localparam int          IdxW         = $clog2(NumHosts);

    typedef enum logic {
        StIdle,
        StLocked
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        prio_q, prio_d;
    logic [IdxW-1:0]        owner_q, owner_d;
    logic [LeftW-1:0]       left_q, left_d;

    logic [NumHosts-1:0]    sel_oh;
    logic [IdxW-1:0]        sel_idx;
    logic                   sel_any;
    logic [IdxW-1:0]        mux_idx;
    logic                   locked;
    logic                   hs;
    int unsigned            beats;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (32'(i) == NumHosts - 1) ? '0 : i + 1'b1;
    endfunction

    tl_rr_picker #(
        .N    (NumHosts),
        .IdxW (IdxW)
    ) u_picker (
        .req_i  (host_valid_i),
        .prio_i (prio_q),
        .gnt_o  (sel_oh),
        .idx_o  (sel_idx),
        .any_o  (sel_any)
    );

    assign locked  = (state_q == StLocked);
    assign mux_idx = locked ? owner_q : sel_idx;

    assign dev_opcode_o  = host_opcode_i[mux_idx];
    assign dev_size_o    = host_size_i[mux_idx];
    assign dev_payload_o = host_payload_i[mux_idx];
    assign grant_o       = mux_idx;
    assign locked_o      = locked;

    // Reset gates the handshake outputs directly so nothing leaks while
    // rst_i is held, even though the idle picker still sees requests.
    always_comb begin
        host_ready_o = '0;
        dev_valid_o  = 1'b0;
        if (!rst_i) begin
            if (locked) begin
                host_ready_o[owner_q] = dev_ready_i;
                dev_valid_o           = host_valid_i[owner_q];
            end else begin
                host_ready_o = sel_oh & {NumHosts{dev_ready_i}};
                dev_valid_o  = sel_any;
            end
        end
    end

    assign hs    = dev_valid_o & dev_ready_i;
    assign beats = burst_beats(dev_opcode_o, dev_size_o, NonBurstSize);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        left_d  = left_q;
        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    if (beats == 32'd1) begin
                        prio_d = next_idx(sel_idx);
                    end else begin
                        state_d = StLocked;
                        owner_d = sel_idx;
                        left_d  = LeftW'(beats - 32'd2);
                    end
                end else if (dev_valid_o) begin
                    // Stalled first beat: freeze the choice so the
                    // device sees stable valid/data until accepted.
                    state_d = StLocked;
                    owner_d = sel_idx;
                    left_d  = LeftW'(beats - 32'd1);
                end
            end
            StLocked: begin
                if (hs) begin
                    if (left_q == '0) begin
                        state_d = StIdle;
                        prio_d  = next_idx(owner_q);
                    end else begin
                        left_d = left_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            prio_q  <= '0;
            owner_q <= '0;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            left_q  <= left_d;
        end
    end

endmodule

// File: tb/tb_tl_a_burst_arbiter.sv
// Self-checking bench for tl_a_burst_arbiter: vector table, directed
// corner sequences and randomized traffic against a reference model.
module tb_tl_a_burst_arbiter;

    localparam int N  = 2;
    localparam int PW = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      hv;
    logic [N-1:0]      rdy;
    logic [N-1:0][2:0] op;
    logic [N-1:0][3:0] sz;
    logic [N-1:0][PW-1:0] pl;
    logic              dv;
    logic              dr;
    logic [2:0]        dop;
    logic [3:0]        dsz;
    logic [PW-1:0]     dpl;
    logic              gnt;
    logic              lk;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tl_a_burst_arbiter #(
        .NumHosts     (N),
        .DataWidth    (64),
        .MaxSize      (6),
        .PayloadWidth (PW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .host_valid_i   (hv),
        .host_ready_o   (rdy),
        .host_opcode_i  (op),
        .host_size_i    (sz),
        .host_payload_i (pl),
        .dev_valid_o    (dv),
        .dev_ready_i    (dr),
        .dev_opcode_o   (dop),
        .dev_size_o     (dsz),
        .dev_payload_o  (dpl),
        .grant_o        (gnt),
        .locked_o       (lk)
    );

    typedef struct {
        logic [1:0] v;
        logic [2:0] o0;
        logic [3:0] s0;
        logic [2:0] o1;
        logic [3:0] s1;
        logic       d;
        logic [1:0] e_rdy;
        logic       e_dv;
        logic       e_gnt;
        logic       e_lk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic [1:0] v, logic [2:0] o0, logic [3:0] s0,
        logic [2:0] o1, logic [3:0] s1, logic d,
        logic [1:0] r, logic e_dv, logic g, logic l
    );
        vec_t x;
        x.v = v; x.o0 = o0; x.s0 = s0; x.o1 = o1; x.s1 = s1; x.d = d;
        x.e_rdy = r; x.e_dv = e_dv; x.e_gnt = g; x.e_lk = l;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [1:0] v, input logic [2:0] o0,
                       input logic [3:0] s0, input logic [2:0] o1,
                       input logic [3:0] s1, input logic d);
        hv = v; op[0] = o0; sz[0] = s0; op[1] = o1; sz[1] = s1; dr = d;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who holds the link, how many beats are still owed,
    // and where the round-robin search starts next.
    int m_hold, m_rem, m_ptr;

    function automatic int ref_beats(input int o, input int s);
        if (o < 4 && s > 3) return 1 << (s - 3);
        return 1;
    endfunction

    initial begin
        int    g, n;
        logic  edv, elk, hs;
        logic [1:0] erdy;

        rst = 1'b1; hv = '0; dr = 1'b0;
        op = '0; sz = '0;
        pl[0] = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
        pl[1] = 128'h8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff;

        // Reset state, idle and with live requests
        @(negedge clk);
        chk("rst dv", 128'(dv), 128'(1'b0));
        chk("rst rdy", 128'(rdy), 128'(2'b00));
        chk("rst lk", 128'(lk), 128'(1'b0));
        chk("rst gnt", 128'(gnt), 128'(1'b0));
        put(2'b11, 3'd4, 4'd3, 3'd4, 4'd3, 1'b1);
        chk("rst busy dv", 128'(dv), 128'(1'b0));
        chk("rst busy rdy", 128'(rdy), 128'(2'b00));
        adv();
        rst = 1'b0;

        // Vector table: single Get, stall-lock, fairness, burst lock
        tbl.push_back(mk(2'b10, 4, 3, 4, 3, 1, 2'b10, 1, 1, 0));
        tbl.push_back(mk(2'b11, 4, 3, 4, 3, 0, 2'b00, 1, 0, 0));
        tbl.push_back(mk(2'b11, 4, 3, 4, 3, 1, 2'b01, 1, 0, 1));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(2'b11, 4, 3, 4, 3, 1,
                             (k % 2 == 0) ? 2'b10 : 2'b01, 1,
                             (k % 2 == 0) ? 1'b1 : 1'b0, 0));
        tbl.push_back(mk(2'b10, 4, 3, 4, 3, 1, 2'b10, 1, 1, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(2'b11, 0, 6, 4, 3, 1, 2'b01, 1, 0, k != 0));
        tbl.push_back(mk(2'b11, 0, 6, 4, 3, 1, 2'b10, 1, 1, 0));

        foreach (tbl[i]) begin
            put(tbl[i].v, tbl[i].o0, tbl[i].s0, tbl[i].o1, tbl[i].s1,
                tbl[i].d);
            chk($sformatf("vec%0d rdy", i), 128'(rdy), 128'(tbl[i].e_rdy));
            chk($sformatf("vec%0d dv", i), 128'(dv), 128'(tbl[i].e_dv));
            chk($sformatf("vec%0d gnt", i), 128'(gnt), 128'(tbl[i].e_gnt));
            chk($sformatf("vec%0d lk", i), 128'(lk), 128'(tbl[i].e_lk));
            chk($sformatf("vec%0d pl", i), dpl, pl[tbl[i].e_gnt]);
            adv();
        end

        // Stall stability: host0 waits, host1 arrives late
        for (int k = 0; k < 5; k++) begin
            put(2'b01, 4, 3, 4, 3, 0);
            chk("stall gnt", 128'(gnt), 128'(1'b0));
            chk("stall pl", dpl, pl[0]);
            chk("stall lk", 128'(lk), 128'(k != 0));
            adv();
        end
        for (int k = 0; k < 2; k++) begin
            put(2'b11, 4, 3, 4, 3, 0);
            chk("stall2 gnt", 128'(gnt), 128'(1'b0));
            chk("stall2 pl", dpl, pl[0]);
            chk("stall2 rdy", 128'(rdy), 128'(2'b00));
            adv();
        end
        put(2'b11, 4, 3, 4, 3, 1);
        chk("stall acc rdy", 128'(rdy), 128'(2'b01));
        chk("stall acc gnt", 128'(gnt), 128'(1'b0));
        adv();

        // Bubble: owner drops valid after beat 3 of 8
        put(2'b01, 0, 6, 4, 3, 1);
        chk("bub b1 rdy", 128'(rdy), 128'(2'b01));
        adv();
        for (int k = 0; k < 2; k++) begin
            put(2'b11, 0, 6, 4, 3, 1);
            chk("bub b23 rdy", 128'(rdy), 128'(2'b01));
            adv();
        end
        for (int k = 0; k < 4; k++) begin
            put(2'b10, 0, 6, 4, 3, 1);
            chk("bub gap dv", 128'(dv), 128'(1'b0));
            chk("bub gap lk", 128'(lk), 128'(1'b1));
            chk("bub gap rdy1", 128'(rdy[1]), 128'(1'b0));
            adv();
        end
        for (int k = 0; k < 5; k++) begin
            put(2'b11, 0, 6, 4, 3, 1);
            chk("bub tail rdy", 128'(rdy), 128'(2'b01));
            chk("bub tail lk", 128'(lk), 128'(1'b1));
            adv();
        end
        put(2'b11, 0, 6, 4, 3, 1);
        chk("bub next gnt", 128'(gnt), 128'(1'b1));
        chk("bub next lk", 128'(lk), 128'(1'b0));
        adv();

        // Reset mid-burst, with prio moved off host0 beforehand
        put(2'b01, 4, 3, 4, 3, 1);
        adv();
        put(2'b01, 0, 6, 4, 3, 1);
        adv();
        put(2'b01, 0, 6, 4, 3, 1);
        chk("pre-rst lk", 128'(lk), 128'(1'b1));
        adv();
        rst = 1'b1;
        #1;
        chk("mid-rst dv", 128'(dv), 128'(1'b0));
        chk("mid-rst rdy", 128'(rdy), 128'(2'b00));
        chk("mid-rst lk", 128'(lk), 128'(1'b0));
        adv();
        rst = 1'b0;
        put(2'b11, 4, 3, 4, 3, 1);
        chk("post-rst gnt", 128'(gnt), 128'(1'b0));
        chk("post-rst rdy", 128'(rdy), 128'(2'b01));
        adv();
        put(2'b10, 4, 3, 4, 3, 1);
        chk("post-rst h1 gnt", 128'(gnt), 128'(1'b1));
        chk("post-rst h1 rdy", 128'(rdy), 128'(2'b10));
        chk("post-rst h1 lk", 128'(lk), 128'(1'b0));
        adv();
        put(2'b00, 4, 3, 4, 3, 1);
        chk("post-rst idle dv", 128'(dv), 128'(1'b0));
        chk("post-rst idle lk", 128'(lk), 128'(1'b0));
        adv();

        // Randomized traffic against the reference model
        rst = 1'b1;
        adv();
        rst = 1'b0;
        m_hold = -1; m_rem = 0; m_ptr = 0;
        for (int c = 0; c < 600; c++) begin
            for (int h = 0; h < N; h++) begin
                hv[h] = ($urandom_range(0, 3) != 0);
                op[h] = 3'($urandom_range(0, 7));
                sz[h] = 4'($urandom_range(0, 6));
                pl[h] = {$urandom, $urandom, $urandom, $urandom};
            end
            dr = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (m_hold >= 0) begin
                g = m_hold; edv = hv[g]; elk = 1'b1;
            end else begin
                g = m_ptr; edv = |hv; elk = 1'b0;
                for (int k = N - 1; k >= 0; k--)
                    if (hv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            erdy = '0;
            erdy[g] = dr;
            chk("rnd dv", 128'(dv), 128'(edv));
            chk("rnd lk", 128'(lk), 128'(elk));
            if (elk || edv) begin
                chk("rnd gnt", 128'(gnt), 128'(g));
                chk("rnd rdy", 128'(rdy), 128'(erdy));
                chk("rnd fields", {dop, dsz, dpl[120:0]},
                    {op[g], sz[g], pl[g][120:0]});
            end
            hs = edv && dr;
            @(posedge clk);
            if (m_hold < 0) begin
                if (edv) begin
                    n = ref_beats(int'(op[g]), int'(sz[g])) - (hs ? 1 : 0);
                    if (n == 0) m_ptr = (g + 1) % N;
                    else begin
                        m_hold = g; m_rem = n;
                    end
                end
            end else if (hs) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_ptr = (m_hold + 1) % N;
                    m_hold = -1;
                end
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
